// File: rtl/popcount_frame_accum_if.sv
// Stream bundle for popcount_frame_accum: input beats, per-word count and frame-total handshake.
interface popcount_frame_accum_if #(
  parameter int WIDTH = 32,
  parameter int ACC_W = 16
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             in_mode;
  logic [CNT_W-1:0] word_cnt;
  logic             word_vld;
  logic [ACC_W-1:0] out_total;
  logic             out_sat;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_valid, in_data, in_last, in_mode, out_ready,
    input  in_ready, word_cnt, word_vld, out_total, out_sat, out_valid
  );

  modport slave (
    input  in_valid, in_data, in_last, in_mode, out_ready,
    output in_ready, word_cnt, word_vld, out_total, out_sat, out_valid
  );
endinterface

// File: rtl/popcount_frame_accum.sv
// Three-stage popcount (chunk lookups, word sum, frame accumulate) with a saturating
// frame total presented on a valid/ready output; the whole pipeline stalls on output backpressure.
module popcount_frame_accum #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int ACC_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  popcount_frame_accum_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int NCH   = WIDTH / CHUNK;
  localparam int PC_W  = $clog2(CHUNK + 1);
  localparam int SUM_W = ACC_W + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  function automatic logic [PC_W-1:0] chunk_pop(input logic [CHUNK-1:0] d);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < CHUNK; i++) c = c + PC_W'(d[i]);
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sum_parts(input logic [NCH-1:0][PC_W-1:0] p);
    logic [CNT_W-1:0] s;
    s = '0;
    for (int i = 0; i < NCH; i++) s = s + CNT_W'(p[i]);
    return s;
  endfunction

  function automatic logic [ACC_W-1:0] sat_clamp(input logic [SUM_W-1:0] s);
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction

  state_t                   r_state, w_state_nxt;
  logic [NCH-1:0][PC_W-1:0] r_part_p1, w_part;
  logic                     r_vld_p1, r_last_p1;
  logic [CNT_W-1:0]         r_cnt_p2;
  logic                     r_vld_p2, r_last_p2, r_word_vld;
  logic [ACC_W-1:0]         r_acc, w_acc_nxt, r_total, w_total_nxt;
  logic                     r_sticky, w_sticky_nxt, r_sat, w_sat_nxt;
  logic [WIDTH-1:0]         w_data_m;
  logic [SUM_W-1:0]         w_base, w_sum;
  logic [ACC_W-1:0]         w_clamped;
  logic                     w_out_valid, w_en, w_accept, w_take, w_frame_sat;

  assign w_out_valid = (r_state == HOLD);
  assign w_en        = !(w_out_valid && !bus.out_ready);
  assign w_accept    = bus.in_valid && w_en && !flush;
  assign w_take      = r_vld_p2 && w_en;

  // stage 0 -> 1: optional inversion and per-chunk lookups
  always_comb begin
    w_data_m = bus.in_mode ? ~bus.in_data : bus.in_data;
    w_part   = '0;
    for (int i = 0; i < NCH; i++) w_part[i] = chunk_pop(w_data_m[i*CHUNK +: CHUNK]);
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_part_p1 <= w_part;
      r_last_p1 <= bus.in_last;
    end
  end

  // stage 3: frame accumulation; a beat taken while in HOLD starts the next frame at once
  always_comb begin
    w_state_nxt  = r_state;
    w_acc_nxt    = r_acc;
    w_sticky_nxt = r_sticky;
    w_total_nxt  = r_total;
    w_sat_nxt    = r_sat;
    w_base       = (r_state == ACCUM) ? {1'b0, r_acc} : '0;
    w_sum        = w_base + SUM_W'(r_cnt_p2);
    w_clamped    = sat_clamp(w_sum);
    w_frame_sat  = w_sum[ACC_W] || ((r_state == ACCUM) && r_sticky);
    case (r_state)
      IDLE, ACCUM, HOLD: begin
        if (w_take) begin
          if (r_last_p2) begin
            w_state_nxt  = HOLD;
            w_total_nxt  = w_clamped;
            w_sat_nxt    = w_frame_sat;
            w_acc_nxt    = '0;
            w_sticky_nxt = 1'b0;
          end else begin
            w_state_nxt  = ACCUM;
            w_acc_nxt    = w_clamped;
            w_sticky_nxt = w_frame_sat;
          end
        end else if (r_state == HOLD && bus.out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // stage 1 -> 2 and control state; flush outranks the stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1   <= 1'b0;
      r_vld_p2   <= 1'b0;
      r_last_p2  <= 1'b0;
      r_cnt_p2   <= '0;
      r_word_vld <= 1'b0;
      r_state    <= IDLE;
      r_acc      <= '0;
      r_sticky   <= 1'b0;
      r_total    <= '0;
      r_sat      <= 1'b0;
    end else if (flush) begin
      r_vld_p1   <= 1'b0;
      r_vld_p2   <= 1'b0;
      r_last_p2  <= 1'b0;
      r_cnt_p2   <= '0;
      r_word_vld <= 1'b0;
      r_state    <= IDLE;
      r_acc      <= '0;
      r_sticky   <= 1'b0;
      r_total    <= '0;
      r_sat      <= 1'b0;
    end else begin
      if (w_en) begin
        r_vld_p1 <= w_accept;
        r_vld_p2 <= r_vld_p1;
      end
      if (w_en && r_vld_p1) begin
        r_cnt_p2  <= sum_parts(r_part_p1);
        r_last_p2 <= r_last_p1;
      end
      r_word_vld <= w_en && r_vld_p1;
      r_state    <= w_state_nxt;
      r_acc      <= w_acc_nxt;
      r_sticky   <= w_sticky_nxt;
      r_total    <= w_total_nxt;
      r_sat      <= w_sat_nxt;
    end
  end

  assign bus.in_ready  = w_en;
  assign bus.word_cnt  = r_cnt_p2;
  assign bus.word_vld  = r_word_vld;
  assign bus.out_total = r_total;
  assign bus.out_sat   = r_sat;
  assign bus.out_valid = w_out_valid;
endmodule

// File: tb/tb_popcount_frame_accum.sv
// Bench for popcount_frame_accum: ACC_W=16 and ACC_W=6 instances share one stimulus stream;
// a queue model checks every word count and frame total, directed literals pin the model.
module tb_popcount_frame_accum;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  popcount_frame_accum_if #(.WIDTH(32), .ACC_W(16)) bus ();
  popcount_frame_accum_if #(.WIDTH(32), .ACC_W(6))  sbus ();

  assign sbus.in_valid  = bus.in_valid;
  assign sbus.in_data   = bus.in_data;
  assign sbus.in_last   = bus.in_last;
  assign sbus.in_mode   = bus.in_mode;
  assign sbus.out_ready = bus.out_ready;

  popcount_frame_accum #(.WIDTH(32), .CHUNK(8), .ACC_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus.slave));
  popcount_frame_accum #(.WIDTH(32), .CHUNK(8), .ACC_W(6)) u_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(sbus.slave));

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct { int total; bit sat; } fr_t;
  int  exp_w[$];
  fr_t q16[$];
  fr_t q6[$];
  int  frame_sum = 0;

  function automatic fr_t clampf(input int s, input int w);
    fr_t f;
    int  mx;
    mx      = (1 << w) - 1;
    f.total = (s > mx) ? mx : s;
    f.sat   = (s > mx);
    return f;
  endfunction

  always @(negedge clk) begin
    int  e;
    fr_t f;
    if (!rst_n) begin
      exp_w.delete(); q16.delete(); q6.delete(); frame_sum = 0;
    end else begin
      if (bus.word_vld) begin
        if (exp_w.size() == 0) chk("spurious_word_vld", 1, 0);
        else begin
          e = exp_w.pop_front();
          chk("word_cnt16", bus.word_cnt, e);
          chk("word_cnt6", sbus.word_cnt, e);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q16.size() == 0) chk("spurious_out16", 1, 0);
        else begin
          f = q16.pop_front();
          chk("total16", bus.out_total, f.total);
          chk("sat16", bus.out_sat, f.sat);
        end
      end
      if (sbus.out_valid && sbus.out_ready) begin
        if (q6.size() == 0) chk("spurious_out6", 1, 0);
        else begin
          f = q6.pop_front();
          chk("total6", sbus.out_total, f.total);
          chk("sat6", sbus.out_sat, f.sat);
        end
      end
      if (bus.out_valid && !bus.out_ready) begin
        chk("stall_in_ready", bus.in_ready, 0);
        if (q16.size() != 0) chk("stall_total16", bus.out_total, q16[0].total);
        if (q6.size() != 0) chk("stall_total6", sbus.out_total, q6[0].total);
      end
      if (flush) begin
        exp_w.delete(); q16.delete(); q6.delete(); frame_sum = 0;
      end else if (bus.in_valid && bus.in_ready) begin
        e = $countones(bus.in_mode ? ~bus.in_data : bus.in_data);
        exp_w.push_back(e);
        frame_sum += e;
        if (bus.in_last) begin
          q16.push_back(clampf(frame_sum, 16));
          q6.push_back(clampf(frame_sum, 6));
          frame_sum = 0;
        end
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic l, input logic m);
    int   n;
    logic acc;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_last = l; bus.in_mode = m;
    n = 0;
    do begin
      @(negedge clk); acc = bus.in_ready;
      @(posedge clk); #1; n++;
    end while (!acc && n < 60);
    if (!acc) chk("send_timeout", 0, 1);
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_mode = 1'b0;
  endtask

  task automatic wait_out(input string name, input int et, input int es,
                          input int ets, input int ess, output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.out_valid && lat < 40);
    chk({name, "_valid"}, bus.out_valid, 1);
    chk({name, "_total16"}, bus.out_total, et);
    chk({name, "_sat16"}, bus.out_sat, es);
    chk({name, "_total6"}, sbus.out_total, ets);
    chk({name, "_sat6"}, sbus.out_sat, ess);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_out_valid"}, {bus.out_valid, sbus.out_valid}, 0);
    chk({name, "_out_total"}, bus.out_total, 0);
    chk({name, "_out_sat"}, {bus.out_sat, sbus.out_sat}, 0);
    chk({name, "_word_vld"}, {bus.word_vld, sbus.word_vld}, 0);
    chk({name, "_word_cnt"}, bus.word_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    int n;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.in_mode = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // two-beat frame: counts 32 then 4, total 36 three cycles after the last accept
    send(32'hFFFF_FFFF, 1'b0, 1'b0);
    send(32'h0000_000F, 1'b1, 1'b0);
    @(negedge clk);
    chk("t1_vld_a", bus.word_vld, 1); chk("t1_cnt_a", bus.word_cnt, 32);
    @(negedge clk);
    chk("t1_vld_b", bus.word_vld, 1); chk("t1_cnt_b", bus.word_cnt, 4);
    chk("t1_early", bus.out_valid, 0);
    @(negedge clk);
    chk("t1_valid", bus.out_valid, 1); chk("t1_total", bus.out_total, 36);
    @(posedge clk); #1;

    // count zeros
    send(32'h0000_00FF, 1'b1, 1'b1);
    wait_out("t2", 24, 0, 24, 0, lat);
    chk("t2_lat", lat, 3);
    @(posedge clk); #1;

    // 96 ones saturates the 6-bit total only; next frame clears the sticky flag
    send(32'hFFFF_FFFF, 1'b0, 1'b0);
    send(32'hFFFF_FFFF, 1'b0, 1'b0);
    send(32'hFFFF_FFFF, 1'b1, 1'b0);
    wait_out("t3", 96, 0, 63, 1, lat);
    @(posedge clk); #1;
    send(32'h0000_0001, 1'b1, 1'b0);
    wait_out("t3b", 1, 0, 1, 0, lat);
    @(posedge clk); #1;

    // backpressure for 5 cycles while the next frame streams in
    bus.out_ready = 1'b0;
    fork
      begin
        send(32'h0000_0001, 1'b1, 1'b0);
        send(32'h0000_00FF, 1'b0, 1'b0);
        send(32'h0000_FF00, 1'b0, 1'b0);
        send(32'hFFFF_0000, 1'b1, 1'b0);
      end
      begin
        n = 0;
        while (!bus.out_valid && n < 40) begin @(negedge clk); n++; end
        chk("t4_held_valid", bus.out_valid, 1);
        repeat (5) begin
          @(negedge clk);
          chk("t4_in_ready", bus.in_ready, 0);
          chk("t4_total", bus.out_total, 1);
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
      end
    join
    wait_out("t4b", 32, 0, 32, 0, lat);
    @(posedge clk); #1;

    // back-to-back single-beat frames: totals on consecutive cycles
    send(32'h0000_0003, 1'b1, 1'b0);
    send(32'h0000_0007, 1'b1, 1'b0);
    send(32'h0000_000F, 1'b1, 1'b0);
    wait_out("t5a", 2, 0, 2, 0, lat);
    @(negedge clk);
    chk("t5b_valid", bus.out_valid, 1); chk("t5b_total", bus.out_total, 3);
    @(negedge clk);
    chk("t5c_valid", bus.out_valid, 1); chk("t5c_total", bus.out_total, 4);
    @(posedge clk); #1;

    // asynchronous reset while a total is held and a frame is open
    bus.out_ready = 1'b0;
    send(32'h0000_00FF, 1'b1, 1'b0);
    send(32'h0000_F0F0, 1'b0, 1'b0);
    n = 0;
    while (!bus.out_valid && n < 40) begin @(negedge clk); n++; end
    chk("t6_held", bus.out_total, 8);
    @(posedge clk); #3 rst_n = 1'b0;
    #1 chk_zero("t6_rst");
    @(posedge clk); #1 rst_n = 1'b1; bus.out_ready = 1'b1;
    send(32'h0000_0001, 1'b1, 1'b0);
    wait_out("t6b", 1, 0, 1, 0, lat);
    @(posedge clk); #1;

    // flush overrides the stall and discards the beat presented with it
    bus.out_ready = 1'b0;
    send(32'h0000_000F, 1'b1, 1'b0);
    send(32'hFF00_0000, 1'b0, 1'b0);
    n = 0;
    while (!bus.out_valid && n < 40) begin @(negedge clk); n++; end
    chk("t7_held", bus.out_total, 4);
    @(posedge clk); #1;
    flush = 1'b1; bus.in_valid = 1'b1; bus.in_data = 32'h0000_00FF; bus.in_last = 1'b0;
    @(posedge clk); #1;
    chk_zero("t7_flush");
    flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    send(32'h0000_0003, 1'b1, 1'b0);
    wait_out("t7b", 2, 0, 2, 0, lat);
    repeat (4) @(posedge clk);
    #1;

    // all-zero word in mode 0 still counts as a beat
    send(32'h0000_0000, 1'b0, 1'b0);
    send(32'h0000_0000, 1'b1, 1'b0);
    wait_out("t8", 0, 0, 0, 0, lat);
    repeat (4) @(posedge clk);
    #1;

    chk("drain_words", exp_w.size(), 0);
    chk("drain_q16", q16.size(), 0);
    chk("drain_q6", q6.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
